// File: rtl/rom_stream_pkg.sv
// Shared types and default widths for the ROM burst streamer.
package rom_stream_pkg;
  localparam int D_WIDTH_DEF = 8;
  localparam int A_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/rom_skid_fifo.sv
// Two-entry output buffer; each entry is {last, data}.
module rom_skid_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         not_empty,
  output logic [1:0]   count
);
  logic [W-1:0] mem [0:1];
  logic         wr_ptr;
  logic         rd_ptr;

  // Caller guarantees no write when full and no read when empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) rd_ptr <= ~rd_ptr;
      count <= count + 2'(wr_en) - 2'(rd_en);
    end
  end

  assign rd_data   = mem[rd_ptr];
  assign not_empty = (count != 2'd0);
endmodule

// File: rtl/rom_streamer.sv
// Streams a burst of words from a synchronous ROM onto a valid/ready
// interface, wrapping the address and tolerating arbitrary backpressure.
module rom_streamer
  import rom_stream_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [A_WIDTH-1:0] start_addr,
  input  logic [A_WIDTH:0]   len,
  output logic               busy,
  output logic               done,
  output logic [A_WIDTH-1:0] rom_addr,
  input  logic [D_WIDTH-1:0] rom_data,
  output logic [D_WIDTH-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last
);
  localparam logic [A_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [A_WIDTH:0]   LEN_ONE  = 1;

  state_t             state, state_nxt;
  logic [A_WIDTH-1:0] ptr;
  logic [A_WIDTH-1:0] last_addr;
  logic [A_WIDTH:0]   rem;
  logic               inflight;
  logic               inflight_last;
  logic               accept, issue, fin, zero_start, pop;
  logic [1:0]         count;
  logic [2:0]         occ;
  logic [D_WIDTH:0]   head;

  assign pop = m_valid & m_ready;

  // Occupancy the buffer will have once this cycle's write/pop settle;
  // a new issue is allowed only if its data will still find a free slot.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    issue      = 1'b0;
    fin        = 1'b0;
    zero_start = 1'b0;
    occ        = 3'(count) + 3'(inflight) - 3'(pop);
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            zero_start = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        issue = (rem != '0) && (occ < 3'd2);
        if (issue && rem == LEN_ONE) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && m_last) begin
          fin       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      last_addr     <= '0;
      rem           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      done          <= fin | zero_start;
      inflight      <= issue;
      inflight_last <= issue && (rem == LEN_ONE);
      if (accept) begin
        ptr <= start_addr;
        rem <= len;
      end else if (issue) begin
        ptr       <= ptr + ADDR_ONE;
        last_addr <= ptr;
        rem       <= rem - LEN_ONE;
      end
    end
  end

  // Present the next address only while issuing so the ROM port otherwise
  // holds the last address actually read.
  assign rom_addr = issue ? ptr : last_addr;
  assign busy     = (state != IDLE);

  rom_skid_fifo #(.W(D_WIDTH + 1)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (inflight),
    .wr_data   ({inflight_last, rom_data}),
    .rd_en     (pop),
    .rd_data   (head),
    .not_empty (m_valid),
    .count     (count)
  );

  assign m_data = head[D_WIDTH-1:0];
  assign m_last = head[D_WIDTH];
endmodule

// File: tb/tb_rom_streamer.sv
// Directed bench for rom_streamer with a queue-based reference of the burst stream.
module tb_rom_streamer;
  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   len = '0;
  logic          m_ready = 1'b1;
  logic          busy, done, m_valid, m_last;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data, m_data;
  logic [DW-1:0] mem [0:31];

  rom_streamer #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) mem[i] = 8'h10 + 8'(i);
  always @(posedge clk) rom_data <= mem[rom_addr];

  // Backpressure pattern driver
  bit pat_en = 1'b0;
  int pidx = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  always @(posedge clk) begin
    #1;
    m_ready = pat_en ? pat[pidx % 6] : 1'b1;
    if (pat_en) pidx++;
  end

  int cyc = 0;
  bit armed = 1'b0;
  bit rst_edge = 1'b0;
  always @(posedge clk) begin
    cyc++;
    rst_edge = rst_n;
    if (!rst_n) armed = 1'b1;
  end

  int total = 0;
  int bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: each accepted burst appends its words to a queue
  typedef struct packed { logic [7:0] d; logic l; } word_t;
  word_t expq[$];
  word_t w;
  bit mbusy = 1'b0, cur_busy = 1'b0, pend_done = 1'b0;
  bit pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = '0;
  logic pl = 1'b0;
  logic [7:0] got_d[$];
  bit got_l[$];
  int got_c[$];
  int done_cyc = -1;

  always @(negedge clk) begin
    if (armed) begin
      if (!rst_edge) begin
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_last",  32'(m_last), 0);
        chk("rst_data",  32'(m_data), 0);
        chk("rst_addr",  32'(rom_addr), 0);
      end else begin
        chk("done", 32'(done), 32'(pend_done));
        chk("busy", 32'(busy), 32'(mbusy));
        if (done) done_cyc = cyc;
        if (pv && !pr) begin
          chk("stall_valid", 32'(m_valid), 1);
          chk("stall_data", 32'(m_data), 32'(pd));
          chk("stall_last", 32'(m_last), 32'(pl));
        end
        if (m_valid) begin
          if (expq.size() == 0) chk("extra_valid", 32'(m_valid), 0);
          else begin
            chk("data", 32'(m_data), 32'(expq[0].d));
            chk("last", 32'(m_last), 32'(expq[0].l));
          end
        end
      end
      pend_done = 1'b0;
      cur_busy = mbusy;
      if (!rst_n) begin
        expq.delete();
        mbusy = 1'b0;
        pv = 1'b0;
      end else begin
        if (m_valid && m_ready) begin
          got_d.push_back(m_data);
          got_l.push_back(m_last);
          got_c.push_back(cyc);
          if (expq.size() > 0) begin
            if (expq[0].l) begin
              pend_done = 1'b1;
              mbusy = 1'b0;
            end
            void'(expq.pop_front());
          end
        end
        if (start && !cur_busy) begin
          if (len == 0) pend_done = 1'b1;
          else begin
            mbusy = 1'b1;
            for (int i = 0; i < int'(len); i++) begin
              w.d = 8'h10 + 8'((int'(start_addr) + i) % 32);
              w.l = (i == int'(len) - 1);
              expq.push_back(w);
            end
          end
        end
        pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int a, input int n, output int s);
    start_addr = AW'(a);
    len = (AW+1)'(n);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    int d0 = done_cyc;
    while (done_cyc == d0 && k < 300) begin
      tick();
      k++;
    end
    if (done_cyc == d0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done want done within 300 cycles", nm);
    end
  endtask

  initial begin
    int s, n0, n1, d1, k;
    logic [7:0] e2 [4];
    e2 = '{8'h2E, 8'h2F, 8'h10, 8'h11};
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Basic burst, free-flowing sink
    n0 = got_d.size();
    go(3, 4, s);
    wait_done("t1");
    chk("t1_cnt", 32'(got_d.size() - n0), 4);
    if (got_d.size() - n0 == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t1_data", 32'(got_d[n0+i]), 32'(8'h13 + i));
        chk("t1_cyc", 32'(got_c[n0+i] - s), 32'(3 + i));
        chk("t1_last", 32'(got_l[n0+i]), 32'(i == 3));
      end
    chk("t1_done", 32'(done_cyc - s), 7);

    // Address wrap
    n0 = got_d.size();
    go(30, 4, s);
    wait_done("t2");
    chk("t2_cnt", 32'(got_d.size() - n0), 4);
    if (got_d.size() - n0 == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t2_data", 32'(got_d[n0+i]), 32'(e2[i]));
        chk("t2_last", 32'(got_l[n0+i]), 32'(i == 3));
      end

    // Backpressure
    pat_en = 1'b1;
    tick();
    n0 = got_d.size();
    go(8, 6, s);
    wait_done("t3");
    pat_en = 1'b0;
    chk("t3_cnt", 32'(got_d.size() - n0), 6);
    if (got_d.size() - n0 == 6)
      for (int i = 0; i < 6; i++) begin
        chk("t3_data", 32'(got_d[n0+i]), 32'(8'h18 + i));
        chk("t3_last", 32'(got_l[n0+i]), 32'(i == 5));
      end
    tick();

    // Zero-length burst
    n0 = got_d.size();
    go(9, 0, s);
    wait_done("t4");
    chk("t4_done", 32'(done_cyc - s), 1);
    repeat (4) tick();
    chk("t4_cnt", 32'(got_d.size() - n0), 0);

    // Reset in the middle of a burst
    n0 = got_d.size();
    go(5, 8, s);
    k = 0;
    while (got_d.size() < n0 + 2 && k < 50) begin
      tick();
      k++;
    end
    chk("t5_two_words", 32'(got_d.size() >= n0 + 2), 1);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n1 = got_d.size();
    d1 = done_cyc;
    repeat (10) tick();
    chk("t5_no_data", 32'(got_d.size() - n1), 0);
    chk("t5_no_done", 32'(done_cyc), 32'(d1));
    n0 = got_d.size();
    go(0, 2, s);
    wait_done("t5");
    chk("t5_cnt", 32'(got_d.size() - n0), 2);
    if (got_d.size() - n0 == 2) begin
      chk("t5_d0", 32'(got_d[n0]), 32'h10);
      chk("t5_d1", 32'(got_d[n0+1]), 32'h11);
      chk("t5_last", 32'(got_l[n0+1]), 1);
    end

    // Full-ROM burst with a stray start that must be ignored
    n0 = got_d.size();
    go(0, 32, s);
    tick();
    start_addr = 5'd7;
    len = 6'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t6");
    chk("t6_cnt", 32'(got_d.size() - n0), 32);
    if (got_d.size() - n0 == 32)
      for (int i = 0; i < 32; i++) begin
        chk("t6_data", 32'(got_d[n0+i]), 32'(8'h10 + i));
        chk("t6_last", 32'(got_l[n0+i]), 32'(i == 31));
      end
    chk("t6_done", 32'(done_cyc - s), 35);
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
